// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared types and constants for the instruction-memory controller.
//          - imem_state_e : controller FSM state encoding
//          - IMEM_PAR_W   : width of a parity-protected SRAM word (data + parity)
// Rev    : 1.0  initial release
// ============================================================================
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } imem_state_e;

  // 32 data bits plus one even-parity bit in the MSB
  localparam int IMEM_PAR_W = 33;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/imem_parity_chk.sv
`default_nettype none
// ============================================================================
// Module : imem_parity_chk
// Brief  : Combinational even-parity check of one SRAM read word.
//          Only instantiated when INSTR_MEM_PARITY_EN is defined.
// Ports  : data       in  [IMEM_PAR_W-1:0]  {parity, data[31:0]}
//          parity_err out  1                stored parity disagrees with data
// Rev    : 1.0  initial release
// ============================================================================
module imem_parity_chk
  import riscv_pkg::*;
(
  input  logic [IMEM_PAR_W-1:0] data,
  output logic                  parity_err
);

  // Even parity: stored bit equals XOR of the data bits, so any difference
  // leaves a 1 after folding the stored bit in.
  assign parity_err = data[IMEM_PAR_W-1] ^ (^data[IMEM_PAR_W-2:0]);

endmodule : imem_parity_chk
`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : instr_mem_ctrl
// Brief  : Instruction-memory slave controller between the fetch stage
//          (req/gnt/valid) and a single-port synchronous SRAM with 1-cycle
//          read latency. Inserts WAIT_STATES wait cycles, flags misaligned
//          and out-of-range fetches as bus errors, and returns exactly one
//          in-order response per granted request.
// Params : MEM_DEPTH   SRAM depth in words (power of two, >= 4)
//          BASE_ADDR   byte address of SRAM word 0
//          WAIT_STATES cycles between grant and SRAM access (0..7)
// Ports  : clk, reset (async, active high)
//          instr_req/instr_addr      fetch request in
//          instr_gnt                 request accepted this cycle
//          instr_valid/rdata/err     response, one cycle per granted request
//          mem_cs/mem_addr           SRAM read strobe and word address
//          mem_rdata                 SRAM data, valid the cycle after mem_cs
// Macro  : INSTR_MEM_PARITY_EN - mem_rdata widens to 33 bits (bit 32 = even
//          parity) and a parity mismatch on a legal access raises instr_err.
// Rev    : 1.0  initial release
// ============================================================================
module instr_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int          MEM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_req,
  input  logic [31:0]                  instr_addr,
  output logic                         instr_gnt,
  output logic [31:0]                  instr_rdata,
  output logic                         instr_err,
  output logic                         instr_valid,
  output logic                         mem_cs,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
`ifdef INSTR_MEM_PARITY_EN
  input  logic [IMEM_PAR_W-1:0]        mem_rdata
`else
  input  logic [31:0]                  mem_rdata
`endif
);

  localparam int         c_aw      = $clog2(MEM_DEPTH);
  localparam logic       c_ws0     = (WAIT_STATES == 0);
  localparam logic [2:0] c_ws_load = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  imem_state_e       r_state;
  logic [2:0]        r_cnt;
  logic              r_pending;
  logic              r_err;
  logic [c_aw-1:0]   r_addr;

  logic [31:0]       w_word;
  logic              w_err;

  // Unsigned subtract: addresses below BASE_ADDR wrap to a huge offset, but
  // the explicit below-base test keeps them from ever aliasing into the SRAM.
  assign w_word = (instr_addr - BASE_ADDR) >> 2;
  assign w_err  = (instr_addr[1:0] != 2'b00)
                | (instr_addr < BASE_ADDR)
                | (w_word >= 32'(MEM_DEPTH));

  assign instr_gnt = instr_req & (r_state == IDLE) & ~reset;

  // Zero wait states: access happens in the grant cycle on the live address.
  // Otherwise: access happens in ACCESS on the address latched at grant.
  assign mem_cs   = (c_ws0 & instr_gnt & ~w_err)
                  | ((r_state == ACCESS) & ~r_err);
  assign mem_addr = mem_cs ? ((r_state == ACCESS) ? r_addr : w_word[c_aw-1:0])
                           : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_pending <= 1'b0;
      case (r_state)
        IDLE: begin
          if (instr_gnt) begin
            r_err  <= w_err;
            r_addr <= w_word[c_aw-1:0];
            if (c_ws0) begin
              r_pending <= 1'b1;
            end else begin
              r_cnt   <= c_ws_load;
              // With one wait state the counter is already exhausted, so the
              // access follows the grant directly to keep mem_cs at T+1.
              r_state <= (c_ws_load == 3'd0) ? ACCESS : WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_pending <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // r_err still holds the responding request's flag in the valid cycle: a new
  // grant in that same cycle only overwrites it at the following edge.
  assign instr_valid = r_pending;
  assign instr_rdata = (r_pending & ~r_err) ? mem_rdata[31:0] : 32'd0;

`ifdef INSTR_MEM_PARITY_EN
  logic w_par_err;

  imem_parity_chk u_parity_chk (
    .data       (mem_rdata),
    .parity_err (w_par_err)
  );

  assign instr_err = r_pending & (r_err | w_par_err);
`else
  assign instr_err = r_pending & r_err;
`endif

endmodule : instr_mem_ctrl
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_mem_ctrl
// Brief  : Self-checking bench for instr_mem_ctrl. Three controller instances
//          (WAIT_STATES 0/2/3, BASE_ADDR 0/0/0x8000_0000) each with an SRAM
//          model; a scoreboard queue holds expected responses.
// Macro  : INSTR_MEM_PARITY_EN selects the 33-bit SRAM word model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_mem_ctrl;

`ifdef INSTR_MEM_PARITY_EN
  localparam int RW = 33;
`else
  localparam int RW = 32;
`endif
  localparam int          DEPTH     = 1024;
  localparam int          WS_P   [3] = '{0, 2, 3};
  localparam logic [31:0] BASE_P [3] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000};

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req;
  logic [31:0] addr  [3];
  logic [2:0]  gnt, valid, err, cs;
  logic [31:0] rdata [3];
  logic [9:0]  maddr [3];

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // SRAM content: word 1023 holds 1 (and a wrong parity bit in parity builds)
  function automatic logic [31:0] word_data(input logic [9:0] w);
    return (w == 10'd1023) ? 32'h0000_0001 : (32'hC0DE_0000 | {22'd0, w});
  endfunction

  function automatic logic [RW-1:0] model_rd(input logic [9:0] w);
`ifdef INSTR_MEM_PARITY_EN
    return {((w == 10'd1023) ? 1'b0 : ^word_data(w)), word_data(w)};
`else
    return word_data(w);
`endif
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [RW-1:0] rd;
    always @(posedge clk) if (cs[g]) rd <= model_rd(maddr[g]);

    instr_mem_ctrl #(
      .MEM_DEPTH   (DEPTH),
      .BASE_ADDR   (BASE_P[g]),
      .WAIT_STATES (WS_P[g])
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .instr_req   (req[g]),
      .instr_addr  (addr[g]),
      .instr_gnt   (gnt[g]),
      .instr_rdata (rdata[g]),
      .instr_err   (err[g]),
      .instr_valid (valid[g]),
      .mem_cs      (cs[g]),
      .mem_addr    (maddr[g]),
      .mem_rdata   (rd)
    );
  end

  // Expected response for a request to instance k at byte address a
  task automatic push_exp(input int k, input logic [31:0] a);
    exp_t        e;
    logic [33:0] a34, lo34, hi34;
    logic [31:0] off;
    a34    = {2'b00, a};
    lo34   = {2'b00, BASE_P[k]};
    hi34   = lo34 + 34'(DEPTH * 4);
    off    = a - BASE_P[k];
    e.inst = 2'(k);
    e.err  = (a[1:0] != 2'b00) || (a34 < lo34) || (a34 >= hi34);
    e.data = e.err ? 32'h0 : word_data(off[11:2]);
`ifdef INSTR_MEM_PARITY_EN
    if (!e.err && off[11:2] == 10'd1023) e.err = 1'b1;
`endif
    sb.push_back(e);
  endtask

  // Response monitor: every valid pops and checks the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (valid[k] === 1'b1) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL resp_unexpected[%0d]: got data=%h err=%b, required no response", k, rdata[k], err[k]);
        end else begin
          e = sb.pop_front();
          if (e.inst != 2'(k) || rdata[k] !== e.data || err[k] !== e.err) begin
            tests_failed++;
            $display("FAIL resp[%0d]: got data=%h err=%b, required inst=%0d data=%h err=%b",
                     k, rdata[k], err[k], e.inst, e.data, e.err);
          end
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    req = 3'b111;
    for (int k = 0; k < 3; k++) addr[k] = BASE_P[k];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({gnt[k], valid[k], err[k], cs[k], rdata[k], maddr[k]} !== 46'd0) begin
        tests_failed++;
        $display("FAIL reset[%0d]: gnt=%b valid=%b err=%b cs=%b rdata=%h maddr=%h, required all 0",
                 k, gnt[k], valid[k], err[k], cs[k], rdata[k], maddr[k]);
      end
    end
    @(posedge clk); #1;
    req   = 3'b000;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tbl [3] = '{32'h0, 32'h4, 32'h8};
    logic        eg, ev;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c < 3) begin
        req[0]  = 1'b1;
        addr[0] = a_tbl[c];
        push_exp(0, a_tbl[c]);
      end else begin
        req[0] = 1'b0;
      end
      @(negedge clk);
      eg = (c < 3);
      ev = (c >= 1 && c <= 3);
      tests_run++;
      if (gnt[0] !== eg || cs[0] !== eg || valid[0] !== ev) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d: gnt=%b cs=%b valid=%b, required gnt=%b cs=%b valid=%b",
                 c, gnt[0], cs[0], valid[0], eg, eg, ev);
      end
      if (c < 3) begin
        tests_run++;
        if (maddr[0] !== 10'(c)) begin
          tests_failed++;
          $display("FAIL b2b_addr%0d: mem_addr=%0d, required %0d", c, maddr[0], c);
        end
      end
    end
    drain();
  endtask

  task automatic test_wait_states();
    logic eg, ec, ev;
    @(posedge clk); #1;
    req[1]  = 1'b1;
    addr[1] = 32'h10;
    push_exp(1, 32'h10);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      eg = (c == 0) || (c == 3);
      ec = (c == 2);
      ev = (c == 3);
      if (c == 3) push_exp(1, 32'h10);
      tests_run++;
      if (gnt[1] !== eg || cs[1] !== ec || valid[1] !== ev) begin
        tests_failed++;
        $display("FAIL ws2_cycle%0d: gnt=%b cs=%b valid=%b, required gnt=%b cs=%b valid=%b",
                 c, gnt[1], cs[1], valid[1], eg, ec, ev);
      end
      if (c == 2) begin
        tests_run++;
        if (maddr[1] !== 10'd4) begin
          tests_failed++;
          $display("FAIL ws2_addr: mem_addr=%0d, required 4", maddr[1]);
        end
      end
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
    drain();
  endtask

  // One request: waits for grant, then checks mem_cs count, timing and address
  task automatic single_req(input int k, input logic [31:0] a);
    int          guard, cs_cnt, cs_cyc;
    logic [9:0]  cs_addr;
    logic [33:0] a34, lo34, hi34;
    logic [31:0] off;
    logic        exp_e;
    guard   = 0;
    cs_cnt  = 0;
    cs_cyc  = -1;
    cs_addr = '0;
    a34     = {2'b00, a};
    lo34    = {2'b00, BASE_P[k]};
    hi34    = lo34 + 34'(DEPTH * 4);
    off     = a - BASE_P[k];
    exp_e   = (a[1:0] != 2'b00) || (a34 < lo34) || (a34 >= hi34);
    @(posedge clk); #1;
    req[k]  = 1'b1;
    addr[k] = a;
    @(negedge clk);
    while (gnt[k] !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (gnt[k] !== 1'b1) begin
      tests_failed++;
      $display("FAIL grant_timeout[%0d] addr=%h: gnt=%b, required 1 within 20 cycles", k, a, gnt[k]);
      req[k] = 1'b0;
      return;
    end
    push_exp(k, a);
    for (int c = 0; c <= WS_P[k] + 1; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        req[k] = 1'b0;
        @(negedge clk);
      end
      if (cs[k] === 1'b1) begin
        cs_cnt++;
        cs_cyc  = c;
        cs_addr = maddr[k];
      end
    end
    tests_run++;
    if (cs_cnt != (exp_e ? 0 : 1)) begin
      tests_failed++;
      $display("FAIL cs_count[%0d] addr=%h: mem_cs cycles=%0d, required %0d", k, a, cs_cnt, exp_e ? 0 : 1);
    end
    if (!exp_e) begin
      tests_run++;
      if (cs_cyc != WS_P[k] || cs_addr !== off[11:2]) begin
        tests_failed++;
        $display("FAIL cs_timing[%0d] addr=%h: cycle=%0d mem_addr=%0d, required cycle=%0d mem_addr=%0d",
                 k, a, cs_cyc, cs_addr, WS_P[k], off[11:2]);
      end
    end
    drain();
  endtask

  task automatic test_addr_errors();
    single_req(2, 32'h8000_1000);   // one past the top
    single_req(2, 32'h7FFF_FFFC);   // below base, wraps
    single_req(2, 32'h8000_0000);   // first word
    single_req(2, 32'h8000_0FFC);   // last word
    single_req(0, 32'h0000_1000);   // one past the top, base 0
  endtask

  task automatic test_misaligned();
    single_req(0, 32'h0000_0002);
    single_req(1, 32'h0000_0013);
  endtask

  // Last word of instance 0 holds 1; in parity builds its parity bit is wrong
  task automatic test_boundary_parity();
    single_req(0, 32'h0000_0FFC);
  endtask

  task automatic test_reset_abort();
    logic ec;
    @(posedge clk); #1;
    req[2]  = 1'b1;
    addr[2] = 32'h8000_0010;
    @(negedge clk);
    tests_run++;
    if (gnt[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_grant: gnt=%b, required 1", gnt[2]);
    end
    @(posedge clk); #1;
    req[2] = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({gnt[2], valid[2], err[2], cs[2], rdata[2], maddr[2]} !== 46'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs: gnt=%b valid=%b err=%b cs=%b rdata=%h maddr=%h, required all 0",
               gnt[2], valid[2], err[2], cs[2], rdata[2], maddr[2]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset   = 1'b0;
    req[2]  = 1'b1;
    addr[2] = 32'h8000_0FFC;
    @(negedge clk);
    tests_run++;
    if (gnt[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_grant: gnt=%b, required 1", gnt[2]);
    end
    push_exp(2, 32'h8000_0FFC);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      req[2] = 1'b0;
      @(negedge clk);
      ec = (c == 3);
      tests_run++;
      if (cs[2] !== ec || valid[2] !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset_cycle%0d: cs=%b valid=%b, required cs=%b valid=0", c, cs[2], valid[2], ec);
      end
      if (c == 3) begin
        tests_run++;
        if (maddr[2] !== 10'd1023) begin
          tests_failed++;
          $display("FAIL post_reset_addr: mem_addr=%0d, required 1023", maddr[2]);
        end
      end
    end
    drain();
  endtask

  initial begin
    req = 3'b000;
    for (int k = 0; k < 3; k++) addr[k] = 32'h0;
    repeat (2) @(posedge clk);
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_addr_errors();
    test_misaligned();
    test_boundary_parity();
    test_reset_abort();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_instr_mem_ctrl
`default_nettype wire

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Instruction-memory slave controller that sits directly upstream of the fetch stage. It terminates the fetch stage's req/gnt/valid instruction interface and drives a single-port synchronous instruction SRAM with 1-cycle read latency. It inserts a configurable number of wait states, flags out-of-range and misaligned fetches as bus errors, and always returns exactly one in-order response per granted request. That last guarantee lets the fetch stage's flush handling rely on every outstanding request completing.

## Interface
- MEM_DEPTH, 1024, SRAM depth in 32-bit words; power of two, ≥ 4
- BASE_ADDR, 32'h0000_0000, byte address of SRAM word 0; MEM_DEPTH*4-aligned
- WAIT_STATES, 0, extra cycles between grant and SRAM access; legal range 0..7
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- instr_req  input  1  fetch request
- instr_addr  input  32  fetch byte address
- instr_gnt  output  1  request accepted this cycle
- instr_rdata  output  32  read data, qualified by instr_valid
- instr_err  output  1  bus error, qualified by instr_valid
- instr_valid  output  1  response valid, one cycle per granted request
- mem_cs  output  1  SRAM read strobe
- mem_addr  output  $clog2(MEM_DEPTH)  SRAM word address
- mem_rdata  input  32 (33 with parity)  SRAM read data, valid the cycle after mem_cs

## Operation
- State machine with three states: IDLE, WAIT, ACCESS.
- instr_gnt = instr_req & (state==IDLE) & ~reset. Grant is combinational; the request is accepted on that edge.
- Address check on acceptance. Word offset = (instr_addr − BASE_ADDR) >> 2, computed 32-bit unsigned.
  - Error if instr_addr[1:0] != 0.
  - Error if instr_addr < BASE_ADDR.
  - Error if offset ≥ MEM_DEPTH.
- WAIT_STATES=0:
  - Stays in IDLE.
  - On an accepted legal request, mem_cs=1 and mem_addr=offset in the same cycle.
  - Back-to-back requests are granted every cycle.
- WAIT_STATES>0:
  - IDLE→WAIT on acceptance. Address and error flag are latched and the counter is loaded with WAIT_STATES−1.
  - WAIT decrements the counter and moves to ACCESS when it reaches 0.
  - ACCESS asserts mem_cs for legal requests (held address), then returns to IDLE.
- Erroneous requests never assert mem_cs. They follow identical timing, with instr_err=1 and instr_rdata=0.
- Response path:
  - A pending flag is set in the access cycle.
  - In the next cycle instr_valid=1, instr_rdata=mem_rdata[31:0] (or 0 on error), instr_err=error flag.
- Requests are never dropped and responses are never reordered. The controller does not observe the fetch stage's flush; it keeps returning data.

## Timing
- Reset values: state=IDLE, counter=0, pending=0, error flag=0, instr_gnt=0, instr_valid=0, instr_err=0, instr_rdata=0, mem_cs=0, mem_addr=0.
- Grant at edge T, then mem_cs in cycle T+WAIT_STATES, then instr_valid in cycle T+WAIT_STATES+1.
- Throughput:
  - WAIT_STATES=0: 1 request/cycle.
  - Otherwise: 1 per WAIT_STATES+1 cycles. The next grant can coincide with the previous instr_valid.
- A request held while not granted must keep its address stable. The controller samples it only on the granting cycle.
- Reset mid-operation (WAIT/ACCESS, or pending set) aborts immediately. No instr_valid is produced for the aborted request.
- Offset wrap: an address below BASE_ADDR underflows to a large offset and must flag an error, not alias into the SRAM.

## Configuration
- INSTR_MEM_PARITY_EN defined:
  - mem_rdata is 33 bits, bit 32 = even parity over [31:0].
  - A mismatch on a legal access sets instr_err=1 with instr_rdata still driven from mem_rdata[31:0].
- INSTR_MEM_PARITY_EN undefined:
  - mem_rdata is 32 bits.
  - instr_err reflects only address errors.

## Structure
- Shared package riscv_pkg holds the FSM state enum type (imem_state_e) and the parity-check width constant.
- One sub-module, imem_parity_chk (combinational XOR reduction plus compare), instantiated only under INSTR_MEM_PARITY_EN.
- Counter and FSM stay in the top module.

## Test plan
- WAIT_STATES=0, BASE_ADDR=0, requests 0x0, 0x4, 0x8 on consecutive cycles -> grant each cycle; mem_addr 0,1,2; instr_valid 3 consecutive cycles returning SRAM words 0,1,2, instr_err=0.
- WAIT_STATES=2, request 0x10 held high -> grant at T; mem_cs and mem_addr=4 at T+2; instr_valid at T+3; next grant at T+3.
- MEM_DEPTH=1024, BASE_ADDR=0x8000_0000:
  - request 0x8000_1000 -> no mem_cs; instr_valid with instr_err=1, rdata=0.
  - request 0x7FFF_FFFC -> same response.
- Request 0x0000_0002 (misaligned) -> instr_err=1, no mem_cs.
- WAIT_STATES=3, assert reset one cycle after grant -> outputs return to reset values; no instr_valid follows; next request is granted immediately after reset release.
- INSTR_MEM_PARITY_EN, SRAM word 0x0000_0001 stored with parity bit 0 -> instr_valid, instr_err=1, instr_rdata=0x0000_0001.
